// File: rtl/mem_io_pkg.sv
// Shared definitions for the data-side memory/I/O responder: FSM state codes,
// access-target classification and the I/O register offsets.
package mem_io_pkg;

  // FSM state codes, kept as plain constants so legacy code can share them.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Where a latched request is routed.
  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_IO,
    TGT_UNMAPPED
  } target_e;

  // Register offsets inside the I/O page.
  localparam logic [7:0] LED_OFF = 8'h00;
  localparam logic [7:0] SW_OFF  = 8'h01;
  localparam logic [7:0] CNT_OFF = 8'h02;

  // Coarse address decode. The whole I/O page classifies as TGT_IO; unused
  // offsets inside the page are flagged later by the register bank's hit output.
  function automatic target_e decode_target(input logic [15:0] addr,
                                            input int unsigned ram_aw,
                                            input logic [15:0] io_base);
    target_e tgt;
    if (32'(addr) < (32'd1 << ram_aw)) begin
      tgt = TGT_RAM;
    end else if ((addr >= io_base) && (32'(addr) <= 32'(io_base) + 32'h0000_00FF)) begin
      tgt = TGT_IO;
    end else begin
      tgt = TGT_UNMAPPED;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/io_reg_bank.sv
// Memory-mapped board I/O: LED register, 2-flop switch synchronizer and a
// free-running 16-bit cycle counter. Reads are combinational on the offset.
module io_reg_bank
  import mem_io_pkg::*;
#(
  parameter int SW_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [7:0]      off_i,
  input  logic [SW_W-1:0] wdata_i,
  input  logic [SW_W-1:0] switches_i,
  output logic [15:0]     rdata_o,
  output logic            hit_o,
  output logic [SW_W-1:0] leds_o
);

  logic [SW_W-1:0] leds_q;
  logic [SW_W-1:0] sw_meta_q;
  logic [SW_W-1:0] sw_sync_q;
  logic [15:0]     cnt_q;

  // Register state: LED writes, switch synchronizer and the cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cnt_q     <= '0;
    end else begin
      sw_meta_q <= switches_i;
      sw_sync_q <= sw_meta_q;
      cnt_q     <= cnt_q + 16'd1;
      // Only the LED register is writable; other offsets drop the write silently.
      if (we_i && (off_i == LED_OFF)) begin
        leds_q <= wdata_i;
      end
    end
  end

  // Read mux; hit marks the offsets that exist (writes to read-only ones still hit).
  always_comb begin
    rdata_o = '0;
    hit_o   = 1'b0;
    case (off_i)
      LED_OFF: begin
        rdata_o = 16'(leds_q);
        hit_o   = 1'b1;
      end
      SW_OFF: begin
        rdata_o = 16'(sw_sync_q);
        hit_o   = 1'b1;
      end
      CNT_OFF: begin
        rdata_o = cnt_q;
        hit_o   = 1'b1;
      end
      default: begin
        rdata_o = '0;
        hit_o   = 1'b0;
      end
    endcase
  end

  assign leds_o = leds_q;

endmodule

// File: rtl/mem_io_responder.sv
// CPU data-side responder: accepts one load/store at a time, routes it to block
// RAM or the I/O register bank, and answers with a one-cycle Ack (plus Err for
// unmapped addresses).
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter int          RAM_LAT = 1,
  parameter logic [15:0] IO_BASE = 16'hFF00,
  parameter int          SW_W    = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              We,
  input  logic [15:0]       Addr,
  input  logic [15:0]       WData,
  output logic [15:0]       RData,
  output logic              Ack,
  output logic              Busy,
  output logic              Err,
  output logic [RAM_AW-1:0] RamAddr,
  output logic [15:0]       RamWData,
  output logic              RamWe,
  input  logic [15:0]       RamRData,
  input  logic [SW_W-1:0]   Switches,
  output logic [SW_W-1:0]   Leds
);

  logic [1:0]  state_q, state_d;
  target_e     tgt_q, tgt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  lat_q, lat_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        io_we;
  logic [7:0]  io_off;
  logic [15:0] io_rdata;
  logic        io_hit;

  // Offset within the I/O page of the latched address.
  assign io_off = addr_q[7:0] - IO_BASE[7:0];
  assign io_we  = (state_q == ST_ACCESS) && (tgt_q == TGT_IO) && we_q;

  io_reg_bank #(
    .SW_W(SW_W)
  ) u_io_reg_bank (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .we_i      (io_we),
    .off_i     (io_off),
    .wdata_i   (wdata_q[SW_W-1:0]),
    .switches_i(Switches),
    .rdata_o   (io_rdata),
    .hit_o     (io_hit),
    .leds_o    (Leds)
  );

  // Next-state logic: request capture, per-target access timing and response.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    tgt_d   = tgt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          addr_d  = Addr;
          we_d    = We;
          wdata_d = WData;
          tgt_d   = decode_target(Addr, RAM_AW, IO_BASE);
          lat_d   = 2'(RAM_LAT);
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        case (tgt_q)
          TGT_RAM: begin
            if (we_q) begin
              state_d = ST_RESP;
            end else if (lat_q == 2'd0) begin
              // Last ACCESS cycle of a load: RAM data has settled.
              rdata_d = RamRData;
              state_d = ST_RESP;
            end else begin
              lat_d = lat_q - 2'd1;
            end
          end
          TGT_IO: begin
            err_d = !io_hit;
            if (!we_q) begin
              rdata_d = io_rdata;
            end
            state_d = ST_RESP;
          end
          default: begin
            err_d = 1'b1;
            if (!we_q) begin
              rdata_d = '0;
            end
            state_d = ST_RESP;
          end
        endcase
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments make every register update from the values
    // present before the edge, independent of statement order.
    if (Reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_RAM;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign Ack      = (state_q == ST_RESP);
  assign Err      = (state_q == ST_RESP) && err_q;
  assign Busy     = (state_q != ST_IDLE);
  assign RData    = rdata_q;
  assign RamAddr  = addr_q[RAM_AW-1:0];
  assign RamWData = wdata_q;
  assign RamWe    = (state_q == ST_ACCESS) && (tgt_q == TGT_RAM) && we_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder. Two instances: index 0 with
// RAM_LAT=1 and index 1 with RAM_LAT=3, each backed by a behavioural RAM.
module tb_mem_io_responder;

  logic        clk;
  logic        rst       [2];
  logic        req       [2];
  logic        we        [2];
  logic [15:0] addr      [2];
  logic [15:0] wdata     [2];
  logic [15:0] rdata     [2];
  logic        ack       [2];
  logic        busy      [2];
  logic        err       [2];
  logic [9:0]  ram_addr  [2];
  logic [15:0] ram_wdata [2];
  logic        ram_we    [2];
  logic [15:0] ram_rdata [2];
  logic [9:0]  leds      [2];
  logic [9:0]  switches;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural RAMs with 1- and 3-cycle read latency.
  bit [15:0] mem  [2][1024];
  bit [15:0] pipe [2][3];

  // Reference model state.
  bit [15:0] ref_ram   [2][1024];
  bit [9:0]  ref_leds  [2];
  bit [15:0] exp_rdata [2];
  int        edge_n = 0;
  int        last_rst [2];

  mem_io_responder #(.RAM_AW(10), .RAM_LAT(1), .IO_BASE(16'hFF00), .SW_W(10)) u_dut0 (
    .Clk(clk), .Reset(rst[0]), .Req(req[0]), .We(we[0]), .Addr(addr[0]), .WData(wdata[0]),
    .RData(rdata[0]), .Ack(ack[0]), .Busy(busy[0]), .Err(err[0]), .RamAddr(ram_addr[0]),
    .RamWData(ram_wdata[0]), .RamWe(ram_we[0]), .RamRData(ram_rdata[0]),
    .Switches(switches), .Leds(leds[0])
  );

  mem_io_responder #(.RAM_AW(10), .RAM_LAT(3), .IO_BASE(16'hFF00), .SW_W(10)) u_dut1 (
    .Clk(clk), .Reset(rst[1]), .Req(req[1]), .We(we[1]), .Addr(addr[1]), .WData(wdata[1]),
    .RData(rdata[1]), .Ack(ack[1]), .Busy(busy[1]), .Err(err[1]), .RamAddr(ram_addr[1]),
    .RamWData(ram_wdata[1]), .RamWe(ram_we[1]), .RamRData(ram_rdata[1]),
    .Switches(switches), .Leds(leds[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: write on RamWe, read data delayed through a short pipeline.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_we[d]) mem[d][ram_addr[d]] <= ram_wdata[d];
      pipe[d][0] <= mem[d][ram_addr[d]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  // Edge bookkeeping for the cycle-counter expectation.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) last_rst[d] <= edge_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete request on instance d, checked against the reference model.
  task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd);
    logic [15:0] exp_rd;
    logic        exp_err;
    logic        is_cnt;
    logic        is_ram_store;
    int          exp_lat;
    int          we_cnt;
    logic [9:0]  we_addr;
    logic        got;
    int          lat;
    exp_rd       = exp_rdata[d];
    exp_err      = 1'b0;
    is_cnt       = 1'b0;
    is_ram_store = 1'b0;
    exp_lat      = 1;
    we_cnt       = 0;
    we_addr      = '0;
    got          = 1'b0;
    lat          = 0;
    if (a < 16'h0400) begin
      if (w) begin
        ref_ram[d][a[9:0]] = wd;
        is_ram_store       = 1'b1;
      end else begin
        exp_rd  = ref_ram[d][a[9:0]];
        exp_lat = (d == 0) ? 2 : 4;
      end
    end else if (a >= 16'hFF00) begin
      case (a[7:0])
        8'h00:   if (w) ref_leds[d] = wd[9:0]; else exp_rd = {6'b0, ref_leds[d]};
        8'h01:   if (!w) exp_rd = {6'b0, switches};
        8'h02:   if (!w) is_cnt = 1'b1;
        default: begin exp_err = 1'b1; if (!w) exp_rd = '0; end
      endcase
    end else begin
      exp_err = 1'b1;
      if (!w) exp_rd = '0;
    end

    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) req[d] = 1'b0;
      if (ram_we[d]) begin we_cnt++; we_addr = ram_addr[d]; end
      if (ack[d]) begin got = 1'b1; lat = n; break; end
      @(posedge clk);
    end
    check("ack_seen", 32'(got), 32'd1);
    if (got) begin
      if (is_cnt) exp_rd = 16'(edge_n - 1 - last_rst[d]);
      check("ack_latency", 32'(lat), 32'(exp_lat));
      check("err", 32'(err[d]), 32'(exp_err));
      check("rdata", 32'(rdata[d]), 32'(exp_rd));
      check("ramwe_pulses", 32'(we_cnt), is_ram_store ? 32'd1 : 32'd0);
      if (is_ram_store) check("ram_addr", 32'(we_addr), 32'(a[9:0]));
      @(posedge clk);
      @(negedge clk);
      check("ack_one_cycle", 32'(ack[d]), 32'd0);
      check("idle_after", 32'(busy[d]), 32'd0);
      check("leds", 32'(leds[d]), 32'(ref_leds[d]));
      exp_rdata[d] = exp_rd;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int we_cnt, ack_cnt, acks;
    int we_pos [2];
    int sel;
    logic [15:0] a;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      ref_leds[d] = '0; exp_rdata[d] = '0; last_rst[d] = 0;
    end
    switches = '0;
    req[0]  = 1'b1;
    addr[0] = 16'h0005;

    // Reset held for two cycles with a pending request.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ack", 32'(ack[0]), 32'd0);
      check("rst_ramwe", 32'(ram_we[0]), 32'd0);
      check("rst_rdata", 32'(rdata[0]), 32'd0);
      check("rst_leds", 32'(leds[0]), 32'd0);
      check("rst_busy", 32'(busy[0]), 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0; req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_no_latch", 32'(busy[0]), 32'd0);

    // Directed: RAM store/load, LEDs, switches, unmapped, counter.
    txn(0, 1'b1, 16'h0010, 16'hBEEF);
    txn(0, 1'b0, 16'h0010, 16'h0000);
    txn(0, 1'b1, 16'hFF00, 16'h02A5);
    txn(0, 1'b0, 16'hFF00, 16'h0000);
    switches = 10'h3C1;
    repeat (2) @(negedge clk);
    txn(0, 1'b0, 16'hFF01, 16'h0000);
    txn(0, 1'b0, 16'h8000, 16'h0000);
    txn(0, 1'b1, 16'hFF10, 16'h1234);
    txn(0, 1'b1, 16'hFF01, 16'h0155);
    txn(0, 1'b0, 16'hFF02, 16'h0000);

    // Req held high for six edges: two stores, three cycles apart.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0001; wdata[0] = 16'h1234;
    ref_ram[0][1] = 16'h1234;
    we_cnt = 0; ack_cnt = 0; we_pos[0] = -1; we_pos[1] = -1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 5) req[0] = 1'b0;
      if (ram_we[0]) begin
        if (we_cnt < 2) we_pos[we_cnt] = c;
        we_cnt++;
      end
      if (ack[0]) ack_cnt++;
    end
    check("held_ramwe_pulses", 32'(we_cnt), 32'd2);
    check("held_ramwe_spacing", 32'(we_pos[1] - we_pos[0]), 32'd3);
    check("held_ack_pulses", 32'(ack_cnt), 32'd2);
    txn(0, 1'b0, 16'h0001, 16'h0000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      switches = 10'($urandom);
      repeat (3) @(negedge clk);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 16'($urandom_range(0, 15));
        1:       a = 16'($urandom_range(0, 1023));
        2:       a = ($urandom_range(0, 3) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                                 : (16'hFF00 | 16'($urandom_range(0, 5)));
        default: a = 16'($urandom_range(16'h0400, 16'hFEFF));
      endcase
      txn(0, 1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    // Reset during the ACCESS phase of a RAM_LAT=3 load.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    check("mid_busy", 32'(busy[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    check("mid_rst_busy", 32'(busy[1]), 32'd0);
    check("mid_rst_ramwe", 32'(ram_we[1]), 32'd0);
    check("mid_rst_rdata", 32'(rdata[1]), 32'd0);
    acks = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[1]) acks++;
    end
    check("mid_rst_no_ack", 32'(acks), 32'd0);
    check("mid_rst_rdata_hold", 32'(rdata[1]), 32'd0);
    txn(1, 1'b1, 16'h0020, 16'h5A5A);
    txn(1, 1'b0, 16'h0020, 16'h0000);
    txn(1, 1'b0, 16'hFF02, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
